mt_thread_scheduler: RTL and testbench
======================================

Name: mt_thread_scheduler

Overview:
Fine-grained multithread fetch scheduler for the MT MIPS core. Each cycle it picks which hardware thread's PC fetch issues, in round-robin order over eligible threads. It tracks a per-thread READY/BLOCKED/DISABLED state, driven by block events (d-cache miss, unresolved redirect) and unblock events (miss return, redirect resolved). It sits beside the fetch stage, and its tid feeds the thread_id carried down the decode/ex/mem glue.

Parameters:
NUM_THREADS, 4, number of hardware threads (power of two, 2..8)
TID_WIDTH, 2, width of thread id, equal to log2(NUM_THREADS)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
i_thread_enable  in  NUM_THREADS  per-thread enable mask (bit n = thread n)
i_block_valid  in  1  block event this cycle
i_block_tid  in  TID_WIDTH  thread to block
i_unblock_valid  in  1  unblock event this cycle
i_unblock_tid  in  TID_WIDTH  thread to unblock
i_fetch_ready  in  1  fetch stage accepts the current offer
o_fetch_valid  out  1  an offer is present
o_fetch_tid  out  TID_WIDTH  offered thread
o_squash_valid  out  1  squash in-flight instructions of o_squash_tid
o_squash_tid  out  TID_WIDTH  thread to squash
o_blocked_mask  out  NUM_THREADS  bit n set when thread n is BLOCKED
o_all_stalled  out  1  no thread is READY

Behaviour:
- All outputs are registered. Reset values:
  - o_fetch_valid=0, o_fetch_tid=0, o_squash_valid=0, o_squash_tid=0.
  - o_blocked_mask=0, o_all_stalled=0.
  - rr pointer = NUM_THREADS-1, so the first grant goes to thread 0.
  - Every thread state = READY. The enable mask is applied from the first post-reset cycle.
- Per-thread state machine, evaluated in this priority order each cycle:
  - enable=0 -> DISABLED. Any state, including BLOCKED.
  - DISABLED & enable=1 -> READY.
  - READY/BLOCKED & unblock hit -> READY.
  - then READY & block hit -> BLOCKED.
  - Consequence: same-tid block+unblock in the same cycle ends in BLOCKED.
  - Unblock of a non-BLOCKED thread is ignored.
  - Block of a DISABLED thread is ignored.
- Eligibility this cycle: state==READY, enable=1, and not hit by i_block this cycle. A thread unblocked this cycle is not eligible until the next cycle.
- Grant, computed combinationally and registered into o_fetch_*:
  - Search starts at ptr+1 mod NUM_THREADS and wraps. The first eligible thread wins.
  - No eligible thread -> o_fetch_valid=0 next cycle.
- Handshake:
  - Offer accepted when o_fetch_valid & i_fetch_ready. Then ptr <= o_fetch_tid, and the next cycle offers the next grant, which may be the same tid if it is the only eligible thread.
  - o_fetch_valid & ~i_fetch_ready: o_fetch_tid and ptr are held. The offer is withdrawn (o_fetch_valid=0) only if the held thread is blocked or disabled that cycle. Re-arbitration then happens the following cycle.
  - o_fetch_valid=0: re-arbitrate every cycle regardless of i_fetch_ready.
- Squash:
  - An effective READY->BLOCKED transition gives o_squash_valid=1 and o_squash_tid=that tid for exactly one cycle (the next cycle).
  - An ignored block gives no squash.
  - A single block port means at most one squash per cycle.
- o_blocked_mask: registered image of the BLOCKED states. o_all_stalled = (no thread READY in next state).
- Mid-operation reset: all state returns to reset values on the next edge. Pending blocks are forgotten, and no squash is emitted.
- Tid arithmetic is mod NUM_THREADS. Out-of-range tids cannot occur.

Test Plan:
1. Reset, enable=4'b1111, ready=1 held -> o_fetch_tid sequence 0,1,2,3,0,1; o_fetch_valid=1 from the first post-reset cycle.
2. Block tid 1 while the pointer is at 0 -> next grants 2,3,0,2; o_squash_valid=1, o_squash_tid=1 for one cycle; o_blocked_mask=4'b0010. Unblock tid 1 -> thread 1 re-enters rotation the cycle after.
3. ready=0 for 3 cycles while offering tid 2 -> tid 2 is held stable. Block tid 2 during the hold -> o_fetch_valid=0 the next cycle, then tid 3 is offered.
4. Block tids 0,1,2,3 on successive cycles -> o_fetch_valid=0, o_all_stalled=1, mask=4'b1111. Unblock tid 3 -> tid 3 is offered repeatedly.
5. Same-cycle block and unblock of tid 0 while BLOCKED -> stays BLOCKED; o_squash_valid=0 (no new transition).
6. enable=4'b0101 -> grants alternate 0,2. Drop enable bit 0 while tid 0 is BLOCKED -> DISABLED, mask bit 0 clears. Assert rst mid-run -> all outputs return to reset values.

Source files
------------

// File: rtl/mt_thread_scheduler.sv
// Fine-grained round-robin fetch scheduler for the MT MIPS core.
// Tracks READY/BLOCKED/DISABLED per hardware thread and offers one thread id per cycle to fetch.
module mt_thread_scheduler #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned TID_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] i_thread_enable,
    input  logic                   i_block_valid,
    input  logic [TID_WIDTH-1:0]   i_block_tid,
    input  logic                   i_unblock_valid,
    input  logic [TID_WIDTH-1:0]   i_unblock_tid,
    input  logic                   i_fetch_ready,
    output logic                   o_fetch_valid,
    output logic [TID_WIDTH-1:0]   o_fetch_tid,
    output logic                   o_squash_valid,
    output logic [TID_WIDTH-1:0]   o_squash_tid,
    output logic [NUM_THREADS-1:0] o_blocked_mask,
    output logic                   o_all_stalled
);

    typedef enum logic [1:0] {
        StReady    = 2'd0,
        StBlocked  = 2'd1,
        StDisabled = 2'd2
    } thread_state_e;

    thread_state_e          state_q [NUM_THREADS];
    thread_state_e          state_d [NUM_THREADS];

    logic [NUM_THREADS-1:0] block_hit;
    logic [NUM_THREADS-1:0] unblock_hit;
    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] blocked_d;
    logic [NUM_THREADS-1:0] blocked_mask_q;
    logic                   ready_any_d;
    logic                   all_stalled_q;

    logic [TID_WIDTH-1:0]   ptr_q, ptr_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic [TID_WIDTH-1:0]   fetch_tid_q, fetch_tid_d;
    logic                   squash_valid_q, squash_valid_d;
    logic [TID_WIDTH-1:0]   squash_tid_q, squash_tid_d;

    logic                   accept;
    logic [TID_WIDTH-1:0]   arb_base;
    logic [TID_WIDTH-1:0]   arb_cand;
    logic [TID_WIDTH-1:0]   arb_tid;
    logic                   arb_found;

    // Event decode
    always_comb begin
        block_hit   = '0;
        unblock_hit = '0;
        for (int n = 0; n < NUM_THREADS; n++) begin
            block_hit[n]   = i_block_valid && (i_block_tid == TID_WIDTH'(n));
            unblock_hit[n] = i_unblock_valid && (i_unblock_tid == TID_WIDTH'(n));
        end
    end

    // Per-thread next state; disable dominates, then unblock, then block.
    always_comb begin
        ready_any_d = 1'b0;
        blocked_d   = '0;
        eligible    = '0;
        for (int n = 0; n < NUM_THREADS; n++) begin
            state_d[n] = state_q[n];
            if (!i_thread_enable[n]) begin
                state_d[n] = StDisabled;
            end else if (state_q[n] == StDisabled) begin
                state_d[n] = StReady;
            end else begin
                if (unblock_hit[n] && (state_q[n] == StBlocked)) begin
                    state_d[n] = StReady;
                end
                if (block_hit[n] && (state_d[n] == StReady)) begin
                    state_d[n] = StBlocked;
                end
            end
            blocked_d[n] = (state_d[n] == StBlocked);
            if (state_d[n] == StReady) begin
                ready_any_d = 1'b1;
            end
            // A thread hit by a block this cycle must not win the grant.
            eligible[n] = (state_q[n] == StReady) && i_thread_enable[n] && !block_hit[n];
        end
    end

    // Squash only on a real READY->BLOCKED transition.
    always_comb begin
        squash_valid_d = i_block_valid && i_thread_enable[i_block_tid]
                         && (state_q[i_block_tid] == StReady);
        squash_tid_d   = squash_valid_d ? i_block_tid : squash_tid_q;
    end

    // Round-robin search starting one past the base pointer.
    always_comb begin
        accept    = fetch_valid_q && i_fetch_ready;
        arb_base  = accept ? fetch_tid_q : ptr_q;
        arb_found = 1'b0;
        arb_tid   = fetch_tid_q;
        arb_cand  = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            arb_cand = arb_base + TID_WIDTH'(i);
            if (!arb_found && eligible[arb_cand]) begin
                arb_found = 1'b1;
                arb_tid   = arb_cand;
            end
        end
    end

    // Offer handshake
    always_comb begin
        ptr_d         = ptr_q;
        fetch_valid_d = fetch_valid_q;
        fetch_tid_d   = fetch_tid_q;
        if (accept) begin
            ptr_d         = fetch_tid_q;
            fetch_valid_d = arb_found;
            fetch_tid_d   = arb_tid;
        end else if (fetch_valid_q) begin
            // Held offer is withdrawn only if its thread drops out this cycle.
            fetch_valid_d = !(block_hit[fetch_tid_q] || !i_thread_enable[fetch_tid_q]);
        end else begin
            fetch_valid_d = arb_found;
            fetch_tid_d   = arb_tid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_THREADS; n++) begin
                state_q[n] <= StReady;
            end
            ptr_q          <= TID_WIDTH'(NUM_THREADS - 1);
            fetch_valid_q  <= 1'b0;
            fetch_tid_q    <= '0;
            squash_valid_q <= 1'b0;
            squash_tid_q   <= '0;
            blocked_mask_q <= '0;
            all_stalled_q  <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_THREADS; n++) begin
                state_q[n] <= state_d[n];
            end
            ptr_q          <= ptr_d;
            fetch_valid_q  <= fetch_valid_d;
            fetch_tid_q    <= fetch_tid_d;
            squash_valid_q <= squash_valid_d;
            squash_tid_q   <= squash_tid_d;
            blocked_mask_q <= blocked_d;
            all_stalled_q  <= !ready_any_d;
        end
    end

    assign o_fetch_valid  = fetch_valid_q;
    assign o_fetch_tid    = fetch_tid_q;
    assign o_squash_valid = squash_valid_q;
    assign o_squash_tid   = squash_tid_q;
    assign o_blocked_mask = blocked_mask_q;
    assign o_all_stalled  = all_stalled_q;

endmodule

// File: tb/tb_mt_thread_scheduler.sv
// Bench for mt_thread_scheduler: directed scenarios plus randomized traffic
// checked against a set-based reference model of the thread scheduler.
module tb_mt_thread_scheduler;

    localparam int N  = 4;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  thread_enable = '0;
    logic          block_valid = 1'b0;
    logic [TW-1:0] block_tid = '0;
    logic          unblock_valid = 1'b0;
    logic [TW-1:0] unblock_tid = '0;
    logic          fetch_ready = 1'b0;
    logic          fetch_valid;
    logic [TW-1:0] fetch_tid;
    logic          squash_valid;
    logic [TW-1:0] squash_tid;
    logic [N-1:0]  blocked_mask;
    logic          all_stalled;

    mt_thread_scheduler #(
        .NUM_THREADS(N),
        .TID_WIDTH  (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_thread_enable(thread_enable),
        .i_block_valid  (block_valid),
        .i_block_tid    (block_tid),
        .i_unblock_valid(unblock_valid),
        .i_unblock_tid  (unblock_tid),
        .i_fetch_ready  (fetch_ready),
        .o_fetch_valid  (fetch_valid),
        .o_fetch_tid    (fetch_tid),
        .o_squash_valid (squash_valid),
        .o_squash_tid   (squash_tid),
        .o_blocked_mask (blocked_mask),
        .o_all_stalled  (all_stalled)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sets of blocked and disabled threads; ready = neither.
    bit m_blocked  [N];
    bit m_disabled [N];
    bit m_elig     [N];
    int m_ptr;
    bit e_fv;
    int e_tid;
    bit e_sq;
    int e_sqtid;
    bit e_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void pick(input int base);
        e_fv = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (base + k) % N;
            if (!e_fv && m_elig[c]) begin
                e_fv  = 1'b1;
                e_tid = c;
            end
        end
    endfunction

    task automatic step(input logic [N-1:0] en, input bit bv, input int bt, input bit uv,
                        input int ut, input bit rdy, input bit r);
        int exp_mask;
        bit any_ready;
        thread_enable = en;
        block_valid   = bv;
        block_tid     = TW'(bt);
        unblock_valid = uv;
        unblock_tid   = TW'(ut);
        fetch_ready   = rdy;
        rst           = r;
        e_rst         = r;
        if (r) begin
            for (int n = 0; n < N; n++) begin
                m_blocked[n]  = 1'b0;
                m_disabled[n] = 1'b0;
            end
            m_ptr   = N - 1;
            e_fv    = 1'b0;
            e_tid   = 0;
            e_sq    = 1'b0;
            e_sqtid = 0;
        end else begin
            for (int n = 0; n < N; n++) begin
                m_elig[n] = !m_blocked[n] && !m_disabled[n] && en[n] && !(bv && bt == n);
            end
            e_sq = bv && en[bt] && !m_blocked[bt] && !m_disabled[bt];
            if (e_sq) e_sqtid = bt;
            if (e_fv && rdy) begin
                m_ptr = e_tid;
                pick(m_ptr);
            end else if (e_fv) begin
                if ((bv && bt == e_tid) || !en[e_tid]) e_fv = 1'b0;
            end else begin
                pick(m_ptr);
            end
            for (int n = 0; n < N; n++) begin
                if (!en[n]) begin
                    m_disabled[n] = 1'b1;
                    m_blocked[n]  = 1'b0;
                end else if (m_disabled[n]) begin
                    m_disabled[n] = 1'b0;
                end else begin
                    if (uv && ut == n) m_blocked[n] = 1'b0;
                    if (bv && bt == n) m_blocked[n] = 1'b1;
                end
            end
        end
        exp_mask  = 0;
        any_ready = 1'b0;
        for (int n = 0; n < N; n++) begin
            if (m_blocked[n]) exp_mask |= (1 << n);
            if (!m_blocked[n] && !m_disabled[n]) any_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
        if (e_fv || e_rst) chk("fetch_tid", 32'(fetch_tid), 32'(e_tid));
        chk("squash_valid", 32'(squash_valid), 32'(e_sq));
        if (e_sq || e_rst) chk("squash_tid", 32'(squash_tid), 32'(e_sqtid));
        chk("blocked_mask", 32'(blocked_mask), 32'(exp_mask));
        chk("all_stalled", 32'(all_stalled), e_rst ? 32'd0 : 32'(!any_ready));
    endtask

    initial begin
        int seq [6];
        seq = '{0, 1, 2, 3, 0, 1};

        step(4'hF, 0, 0, 0, 0, 1, 1);
        step(4'hF, 0, 0, 0, 0, 1, 1);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_mask", 32'(blocked_mask), 32'd0);

        // Plain rotation
        for (int i = 0; i < 6; i++) begin
            step(4'hF, 0, 0, 0, 0, 1, 0);
            chk("rot_valid", 32'(fetch_valid), 32'd1);
            chk("rot_tid", 32'(fetch_tid), 32'(seq[i]));
        end

        // Block every thread in turn, then a same-cycle block+unblock of tid 0
        for (int t = 0; t < N; t++) step(4'hF, 1, t, 0, 0, 1, 0);
        chk("stall_all", 32'(all_stalled), 32'd1);
        chk("stall_mask", 32'(blocked_mask), 32'hF);
        chk("stall_valid", 32'(fetch_valid), 32'd0);
        step(4'hF, 1, 0, 1, 0, 1, 0);
        chk("bu_squash", 32'(squash_valid), 32'd0);
        chk("bu_mask", 32'(blocked_mask), 32'hF);
        step(4'hF, 0, 0, 1, 3, 1, 0);
        step(4'hF, 0, 0, 0, 0, 1, 0);
        chk("only3_a", 32'(fetch_tid), 32'd3);
        step(4'hF, 0, 0, 0, 0, 1, 0);
        chk("only3_b", 32'(fetch_tid), 32'd3);
        chk("only3_v", 32'(fetch_valid), 32'd1);

        // Disabling a blocked thread clears its mask bit
        step(4'hE, 0, 0, 0, 0, 1, 0);
        chk("dis_mask0", 32'(blocked_mask[0]), 32'd0);
        step(4'hF, 0, 0, 1, 1, 1, 0);
        step(4'hF, 0, 0, 1, 2, 1, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] en;
            en = ($urandom_range(0, 9) == 0) ? N'($urandom) :
                 (($urandom_range(0, 5) == 0) ? 4'b0101 : 4'hF);
            step(en, $urandom_range(0, 3) == 0, $urandom_range(0, N - 1),
                 $urandom_range(0, 2) == 0, $urandom_range(0, N - 1),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end

        step(4'hF, 1, 1, 0, 0, 1, 1);
        chk("midrst_valid", 32'(fetch_valid), 32'd0);
        chk("midrst_squash", 32'(squash_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
